mem_access: RTL and testbench

- Memory stage of the 5-stage core; sits between execute and writeback.
- Consumes execute outputs: result, store_addr, opcode, funct, rd_addr, exception and nop flags.
- Performs loads and stores over a valid/ready data-memory port and sign/zero-extends load data.
- Back-pressures execute through stall_out, and registers one writeback record per completed instruction.

---
 rtl/mem_access.sv | 196 +++++++++++++++++++
 tb/tb_mem_access.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory stage of the 5-stage core: issues loads/stores on a valid/ready data port,
// extends load data, stalls execute while memory is busy and registers one writeback record.
`ifndef OP_LOAD
`define OP_LOAD      5'b00000
`define OP_STORE     5'b01000
`define OP_ARITH     5'b01100
`define OP_IMM_ARITH 5'b00100
`define OP_JAL       5'b11011
`define OP_JALR      5'b11001
`define OP_LUI       5'b01101
`define OP_AUIPC     5'b00101
`define OP_BRANCH    5'b11000
`endif

module mem_access #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int EX_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipeline_in_valid,
    input  logic [4:0]            opcode_in,
    input  logic [2:0]            funct_in,
    input  logic                  nop_instr_in,
    input  logic [EX_W-1:0]       exception_in,
    input  logic                  exception_in_valid,
    input  logic [XLEN-1:0]       result_in,
    input  logic [XLEN-1:0]       store_addr_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    output logic                  stall_out,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_we,
    output logic [XLEN-1:0]       dmem_req_addr,
    output logic [XLEN-1:0]       dmem_req_wdata,
    output logic [3:0]            dmem_req_wstrb,
    input  logic                  dmem_resp_valid,
    input  logic [XLEN-1:0]       dmem_resp_rdata,
    output logic                  pipeline_out_valid,
    output logic                  wb_en,
    output logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic                  nop_instr_out,
    output logic [EX_W-1:0]       exception_out,
    output logic                  exception_out_valid
);

    typedef enum logic {IDLE, WAIT_RESP} state_t;

    localparam logic [EX_W-1:0] EXC_ILLEGAL    = EX_W'(2);
    localparam logic [EX_W-1:0] EXC_LOAD_MISAL = EX_W'(4);
    localparam logic [EX_W-1:0] EXC_STORE_MISAL = EX_W'(6);

    state_t state, next_state;

    logic            is_load, is_store, is_mem;
    logic            funct_legal, misaligned, writes_rd;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] byte_sel, half_sel, load_data;

    logic            rec_valid, rec_wb_en, rec_exc_valid;
    logic [XLEN-1:0] rec_data;
    logic [EX_W-1:0] rec_exc;

    assign is_load  = (opcode_in == `OP_LOAD);
    assign is_store = (opcode_in == `OP_STORE);
    assign is_mem   = is_load | is_store;
    assign addr     = is_load ? result_in : store_addr_in;

    assign funct_legal = is_load ? (funct_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                 : (funct_in inside {3'b000, 3'b001, 3'b010});
    assign misaligned  = (funct_in[1:0] == 2'b01 && addr[0]) ||
                         (funct_in[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign writes_rd   = opcode_in inside {`OP_ARITH, `OP_IMM_ARITH, `OP_JAL,
                                           `OP_JALR, `OP_LUI, `OP_AUIPC};

    // Request fields come straight from execute: the stall keeps them stable until completion.
    assign dmem_req_we   = is_store;
    assign dmem_req_addr = {addr[XLEN-1:2], 2'b00};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        dmem_req_wstrb = 4'b1111;
        dmem_req_wdata = result_in;
        case (funct_in[1:0])
            2'b00: begin
                dmem_req_wstrb = 4'b0001 << addr[1:0];
                dmem_req_wdata = {(XLEN/8){result_in[7:0]}};
            end
            2'b01: begin
                dmem_req_wstrb = 4'b0011 << addr[1:0];
                dmem_req_wdata = {(XLEN/16){result_in[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sel = dmem_resp_rdata >> {addr[1:0], 3'b000};
    assign half_sel = dmem_resp_rdata >> {addr[1], 4'b0000};

    always_comb begin
        case (funct_in)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel[7:0]};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel[15:0]};
            default: load_data = dmem_resp_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state     = state;
        dmem_req_valid = 1'b0;
        stall_out      = 1'b0;
        rec_valid      = 1'b0;
        rec_wb_en      = 1'b0;
        rec_data       = result_in;
        rec_exc        = '0;
        rec_exc_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (pipeline_in_valid) begin
                    if (nop_instr_in) begin
                        rec_valid = 1'b1;
                    end else if (exception_in_valid) begin
                        rec_valid     = 1'b1;
                        rec_exc       = exception_in;
                        rec_exc_valid = 1'b1;
                    end else if (is_mem && !funct_legal) begin
                        rec_valid     = 1'b1;
                        rec_exc       = EXC_ILLEGAL;
                        rec_exc_valid = 1'b1;
                    end else if (is_mem && misaligned) begin
                        rec_valid     = 1'b1;
                        rec_exc       = is_load ? EXC_LOAD_MISAL : EXC_STORE_MISAL;
                        rec_exc_valid = 1'b1;
                    end else if (is_mem) begin
                        dmem_req_valid = 1'b1;
                        if (!dmem_req_ready) begin
                            stall_out = 1'b1;
                        end else if (is_load) begin
                            stall_out  = 1'b1;
                            next_state = WAIT_RESP;
                        end else begin
                            rec_valid = 1'b1;
                        end
                    end else begin
                        rec_valid = 1'b1;
                        rec_wb_en = writes_rd && (rd_addr_in != '0);
                    end
                end
            end
            WAIT_RESP: begin
                stall_out = !dmem_resp_valid;
                if (dmem_resp_valid) begin
                    rec_valid  = 1'b1;
                    rec_wb_en  = (rd_addr_in != '0);
                    rec_data   = load_data;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bubble cycles clear the valid/enable flags but leave the last record's payload in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipeline_out_valid  <= 1'b0;
            wb_en               <= 1'b0;
            wb_data             <= '0;
            rd_addr_out         <= '0;
            nop_instr_out       <= 1'b0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
        end else begin
            pipeline_out_valid  <= rec_valid;
            wb_en               <= rec_wb_en;
            exception_out_valid <= rec_exc_valid;
            if (rec_valid) begin
                wb_data       <= rec_data;
                rd_addr_out   <= rd_addr_in;
                nop_instr_out <= nop_instr_in;
                exception_out <= rec_exc;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, exceptions, pass-through and reset abort.
module tb_mem_access;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ARITH  = 5'b01100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipeline_in_valid;
    logic [4:0]  opcode_in;
    logic [2:0]  funct_in;
    logic        nop_instr_in;
    logic [3:0]  exception_in;
    logic        exception_in_valid;
    logic [31:0] result_in;
    logic [31:0] store_addr_in;
    logic [4:0]  rd_addr_in;
    logic        stall_out;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        pipeline_out_valid;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [4:0]  rd_addr_out;
    logic        nop_instr_out;
    logic [3:0]  exception_out;
    logic        exception_out_valid;

    int n_checks = 0;
    int n_fails  = 0;

    mem_access dut (
        .clk(clk), .reset(reset),
        .pipeline_in_valid(pipeline_in_valid), .opcode_in(opcode_in), .funct_in(funct_in),
        .nop_instr_in(nop_instr_in), .exception_in(exception_in),
        .exception_in_valid(exception_in_valid), .result_in(result_in),
        .store_addr_in(store_addr_in), .rd_addr_in(rd_addr_in), .stall_out(stall_out),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .pipeline_out_valid(pipeline_out_valid), .wb_en(wb_en), .wb_data(wb_data),
        .rd_addr_out(rd_addr_out), .nop_instr_out(nop_instr_out),
        .exception_out(exception_out), .exception_out_valid(exception_out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [4:0] op, input logic [2:0] f,
                         input logic [31:0] res, input logic [31:0] saddr, input logic [4:0] rd);
        pipeline_in_valid  = valid;
        opcode_in          = op;
        funct_in           = f;
        result_in          = res;
        store_addr_in      = saddr;
        rd_addr_in         = rd;
        nop_instr_in       = 1'b0;
        exception_in       = 4'd0;
        exception_in_valid = 1'b0;
    endtask

    // Issue a load accepted immediately, answer it one cycle later and check the extension.
    task automatic load_once(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] rdata, input logic [31:0] exp);
        drive(1'b1, OP_LOAD, f, a, 32'h0, 5'd7);
        dmem_req_ready  = 1'b1;
        dmem_resp_valid = 1'b0;
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        tick();
        dmem_resp_valid = 1'b0;
        check({tag, "_data"}, wb_data, exp);
    endtask

    initial begin
        drive(1'b0, OP_ARITH, 3'b000, 32'h0, 32'h0, 5'd0);
        dmem_req_ready  = 1'b1;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_pov", pipeline_out_valid, 1'b0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_stall", stall_out, 1'b0);
        check("rst_req_valid", dmem_req_valid, 1'b0);
        reset = 1'b0;
        tick();

        // LW with a three-cycle response latency
        drive(1'b1, OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd5);
        #1;
        check("lw_req_valid", dmem_req_valid, 1'b1);
        check("lw_req_addr", dmem_req_addr, 32'h100);
        check("lw_req_we", dmem_req_we, 1'b0);
        check("lw_stall_c0", stall_out, 1'b1);
        tick();
        check("lw_stall_c1", stall_out, 1'b1);
        check("lw_req_valid_wait", dmem_req_valid, 1'b0);
        check("lw_pov_c1", pipeline_out_valid, 1'b0);
        tick();
        check("lw_stall_c2", stall_out, 1'b1);
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hDEADBEEF;
        #1;
        check("lw_stall_c3", stall_out, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        drive(1'b0, OP_ARITH, 3'b000, 32'h0, 32'h0, 5'd0);
        check("lw_pov", pipeline_out_valid, 1'b1);
        check("lw_wb_data", wb_data, 32'hDEADBEEF);
        check("lw_wb_en", wb_en, 1'b1);
        check("lw_rd", rd_addr_out, 32'd5);
        tick();
        check("lw_pov_once", pipeline_out_valid, 1'b0);

        load_once("lb", 3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
        load_once("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
        load_once("lhu", 3'b101, 32'h102, 32'h80112233, 32'h00008011);
        load_once("lh", 3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
        load_once("lb_lane1", 3'b000, 32'h101, 32'h80112233, 32'h00000022);

        // SH with two cycles of back-pressure
        drive(1'b1, OP_STORE, 3'b001, 32'h1234ABCD, 32'h202, 5'd9);
        dmem_req_ready = 1'b0;
        #1;
        check("sh_req_valid", dmem_req_valid, 1'b1);
        check("sh_addr", dmem_req_addr, 32'h200);
        check("sh_wstrb", dmem_req_wstrb, 4'b1100);
        check("sh_wdata", dmem_req_wdata, 32'hABCDABCD);
        check("sh_we", dmem_req_we, 1'b1);
        check("sh_stall0", stall_out, 1'b1);
        tick();
        check("sh_pov_stalled", pipeline_out_valid, 1'b0);
        check("sh_addr_held", dmem_req_addr, 32'h200);
        check("sh_stall1", stall_out, 1'b1);
        tick();
        dmem_req_ready = 1'b1;
        #1;
        check("sh_stall_rel", stall_out, 1'b0);
        tick();
        check("sh_pov", pipeline_out_valid, 1'b1);
        check("sh_wb_en", wb_en, 1'b0);

        drive(1'b1, OP_STORE, 3'b000, 32'h00000055, 32'h301, 5'd0);
        #1;
        check("sb_wstrb", dmem_req_wstrb, 4'b0010);
        check("sb_wdata", dmem_req_wdata, 32'h55555555);
        check("sb_stall", stall_out, 1'b0);
        tick();

        // Misaligned and illegal accesses never reach memory
        drive(1'b1, OP_LOAD, 3'b010, 32'h101, 32'h0, 5'd4);
        #1;
        check("lw_mis_req", dmem_req_valid, 1'b0);
        check("lw_mis_stall", stall_out, 1'b0);
        tick();
        check("lw_mis_exc_v", exception_out_valid, 1'b1);
        check("lw_mis_exc", exception_out, 4'd4);
        check("lw_mis_wb_en", wb_en, 1'b0);
        drive(1'b1, OP_STORE, 3'b010, 32'h0, 32'h102, 5'd0);
        #1;
        check("sw_mis_req", dmem_req_valid, 1'b0);
        tick();
        check("sw_mis_exc", exception_out, 4'd6);
        drive(1'b1, OP_LOAD, 3'b011, 32'h100, 32'h0, 5'd4);
        tick();
        check("ld_illegal_exc", exception_out, 4'd2);
        drive(1'b1, OP_ARITH, 3'b000, 32'h0, 32'h0, 5'd4);
        exception_in       = 4'd9;
        exception_in_valid = 1'b1;
        tick();
        check("up_exc", exception_out, 4'd9);
        check("up_exc_v", exception_out_valid, 1'b1);

        // Pass-through of non-memory instructions
        drive(1'b1, OP_ARITH, 3'b000, 32'd7, 32'h0, 5'd0);
        #1;
        check("add0_stall", stall_out, 1'b0);
        tick();
        check("add0_wb_en", wb_en, 1'b0);
        check("add0_data", wb_data, 32'd7);
        check("add0_exc_v", exception_out_valid, 1'b0);
        drive(1'b1, OP_ARITH, 3'b000, 32'd7, 32'h0, 5'd3);
        tick();
        check("add3_wb_en", wb_en, 1'b1);
        check("add3_pov", pipeline_out_valid, 1'b1);
        check("add3_rd", rd_addr_out, 32'd3);
        drive(1'b1, OP_BRANCH, 3'b000, 32'd1, 32'h0, 5'd3);
        tick();
        check("br_wb_en", wb_en, 1'b0);
        drive(1'b1, OP_ARITH, 3'b000, 32'd0, 32'h0, 5'd0);
        nop_instr_in = 1'b1;
        tick();
        check("nop_out", nop_instr_out, 1'b1);
        check("nop_pov", pipeline_out_valid, 1'b1);
        drive(1'b0, OP_ARITH, 3'b000, 32'd0, 32'h0, 5'd0);
        tick();
        check("idle_pov", pipeline_out_valid, 1'b0);

        // Reset while waiting for a response; the late response must be ignored
        drive(1'b1, OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, OP_ARITH, 3'b000, 32'd0, 32'h0, 5'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hCAFEF00D;
        #1;
        check("abort_stall", stall_out, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        check("abort_pov", pipeline_out_valid, 1'b0);
        check("abort_wb_data", wb_data, 32'h0);
        check("abort_wb_en", wb_en, 1'b0);
        check("abort_nop", nop_instr_out, 1'b0);
        drive(1'b1, OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd5);
        #1;
        check("abort_idle_req", dmem_req_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
